// File: rtl/uart_rx_if.sv
// Serial receiver bus: line, oversample tick and enable in; received byte, handshake and status out.
interface uart_rx_if;
    logic       baud_uart;
    logic       enable_rx;
    logic       rxd;
    logic       rx_ack;
    logic [7:0] d_out;
    logic       data_valid;
    logic       receiving;
    logic       framing_error;
    logic       parity_error;
    logic       overrun;

    modport master (
        output baud_uart, enable_rx, rxd, rx_ack,
        input  d_out, data_valid, receiving, framing_error, parity_error, overrun
    );

    modport slave (
        input  baud_uart, enable_rx, rxd, rx_ack,
        output d_out, data_valid, receiving, framing_error, parity_error, overrun
    );
endinterface

// File: rtl/uart_rx.sv
// Oversampling 8-bit UART receiver with sticky error flags and a valid/ack handshake.
// Define UART_RX_PARITY_EN to expect an even parity bit between the data bits and the stop bit.
//
// state     | meaning
// IDLE      | line idle, waiting for a falling edge
// START     | qualifying the start bit at its midpoint
// DATA      | sampling 8 data bits, LSB first
// PARITY    | sampling the even parity bit (UART_RX_PARITY_EN only)
// STOP      | sampling the stop bit
// WAIT_IDLE | framing error seen, waiting for the line to return high
module uart_rx #(
    parameter int OVERSAMPLE = 16
) (
    input  logic clk,
    input  logic rst_n,
    uart_rx_if.slave bus
);

    localparam int CW = $clog2(OVERSAMPLE);
    localparam logic [CW-1:0] HALF_LAST = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] FULL_LAST = CW'(OVERSAMPLE - 1);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_IDLE} state_e;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_e;
`endif

    state_e        state_q, state_d;
    logic [1:0]    sync_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    dout_q, dout_d;
    logic          valid_q, valid_d;
    logic          fe_q, fe_d;
    logic          ov_q, ov_d;
`ifdef UART_RX_PARITY_EN
    logic          pe_q, pe_d;
`endif

    logic rxd_s;
    logic tick;
    logic at_half;
    logic at_full;

    assign rxd_s   = sync_q[1];
    assign tick    = bus.baud_uart;
    assign at_half = (cnt_q == HALF_LAST);
    assign at_full = (cnt_q == FULL_LAST);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        dout_d  = dout_q;
        valid_d = valid_q;
        fe_d    = fe_q;
        ov_d    = ov_q;
`ifdef UART_RX_PARITY_EN
        pe_d    = pe_q;
`endif

        // Acknowledge clears first so that a set event later in this block wins.
        if (bus.rx_ack) begin
            valid_d = 1'b0;
            fe_d    = 1'b0;
            ov_d    = 1'b0;
`ifdef UART_RX_PARITY_EN
            pe_d    = 1'b0;
`endif
        end

        if (!bus.enable_rx) begin
            state_d = IDLE;
            cnt_d   = '0;
            bit_d   = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (!rxd_s) begin
                        state_d = START;
                        cnt_d   = '0;
                    end
                end
                START: begin
                    if (tick) begin
                        if (at_half) begin
                            cnt_d   = '0;
                            bit_d   = '0;
                            state_d = rxd_s ? IDLE : DATA;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
                DATA: begin
                    if (tick) begin
                        if (at_full) begin
                            cnt_d   = '0;
                            shift_d = {rxd_s, shift_q[7:1]};
                            bit_d   = bit_q + 3'd1;
                            if (bit_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                                state_d = PARITY;
`else
                                state_d = STOP;
`endif
                            end
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (tick) begin
                        if (at_full) begin
                            cnt_d   = '0;
                            state_d = STOP;
                            if ((^shift_q) ^ rxd_s) begin
                                pe_d = 1'b1;
                            end
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
`endif
                STOP: begin
                    if (tick) begin
                        if (at_full) begin
                            cnt_d = '0;
                            if (rxd_s) begin
                                dout_d  = shift_q;
                                valid_d = 1'b1;
                                if (valid_q && !bus.rx_ack) begin
                                    ov_d = 1'b1;
                                end
                                state_d = IDLE;
                            end else begin
                                fe_d    = 1'b1;
                                state_d = WAIT_IDLE;
                            end
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
                WAIT_IDLE: begin
                    if (rxd_s) begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sync_q  <= 2'b11;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            dout_q  <= '0;
            valid_q <= 1'b0;
            fe_q    <= 1'b0;
            ov_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            pe_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            sync_q  <= {sync_q[0], bus.rxd};
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            dout_q  <= dout_d;
            valid_q <= valid_d;
            fe_q    <= fe_d;
            ov_q    <= ov_d;
`ifdef UART_RX_PARITY_EN
            pe_q    <= pe_d;
`endif
        end
    end

    assign bus.d_out         = dout_q;
    assign bus.data_valid    = valid_q;
    assign bus.receiving     = (state_q != IDLE);
    assign bus.framing_error = fe_q;
    assign bus.overrun       = ov_q;
`ifdef UART_RX_PARITY_EN
    assign bus.parity_error  = pe_q;
`else
    assign bus.parity_error  = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed vector table, corner-case sequences, random frames vs. a frame-level model.
module tb_uart_rx;

    localparam int OS     = 16;
    localparam int DIV    = 4;
    localparam int BITCLK = OS * DIV;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    uart_rx_if bus();

    uart_rx #(.OVERSAMPLE(OS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int vec_cnt = 0;
    int err_cnt = 0;

    // Frame-level model of the receiver's visible state.
    logic [7:0] m_dout;
    logic       m_valid, m_fe, m_pe, m_ov;

    typedef struct {
        logic [7:0] data;
        logic       stop;
        logic       ack;
        logic [7:0] e_dout;
        logic       e_valid;
        logic       e_fe;
        logic       e_ov;
    } vec_t;

    vec_t tbl[7];

    initial begin
        bus.baud_uart = 1'b0;
        forever begin
            repeat (DIV - 1) @(negedge clk);
            bus.baud_uart = 1'b1;
            @(negedge clk);
            bus.baud_uart = 1'b0;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".d_out"},         bus.d_out,         m_dout);
        chk({tag, ".data_valid"},    bus.data_valid,    m_valid);
        chk({tag, ".framing_error"}, bus.framing_error, m_fe);
        chk({tag, ".parity_error"},  bus.parity_error,  m_pe);
        chk({tag, ".overrun"},       bus.overrun,       m_ov);
    endtask

    task automatic model_reset();
        m_dout = 8'h00; m_valid = 1'b0; m_fe = 1'b0; m_pe = 1'b0; m_ov = 1'b0;
    endtask

    task automatic model_frame(input logic [7:0] data, input logic stop, input logic par);
`ifdef UART_RX_PARITY_EN
        if (par != ^data) m_pe = 1'b1;
`endif
        if (stop) begin
            if (m_valid) m_ov = 1'b1;
            m_dout  = data;
            m_valid = 1'b1;
        end else begin
            m_fe = 1'b1;
        end
    endtask

    task automatic line_bit(input logic b);
        bus.rxd = b;
        repeat (BITCLK) @(negedge clk);
    endtask

    task automatic send_bits(input logic [7:0] data, input logic stop, input logic par);
        line_bit(1'b0);
        for (int i = 0; i < 8; i++) line_bit(data[i]);
`ifdef UART_RX_PARITY_EN
        line_bit(par);
`endif
        line_bit(stop);
    endtask

    task automatic idle(input int n);
        bus.rxd = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] data, input logic stop, input logic par);
        send_bits(data, stop, par);
        idle(8 + $urandom_range(0, 20));
        model_frame(data, stop, par);
    endtask

    task automatic do_ack();
        bus.rx_ack = 1'b1;
        @(negedge clk);
        bus.rx_ack = 1'b0;
        m_valid = 1'b0; m_fe = 1'b0; m_pe = 1'b0; m_ov = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        logic [7:0] d;
        logic       s, p;

        tbl[0] = '{8'h30, 1'b1, 1'b1, 8'h30, 1'b1, 1'b0, 1'b0};
        tbl[1] = '{8'h11, 1'b1, 1'b0, 8'h11, 1'b1, 1'b0, 1'b0};
        tbl[2] = '{8'h22, 1'b1, 1'b1, 8'h22, 1'b1, 1'b0, 1'b1};
        tbl[3] = '{8'hA5, 1'b0, 1'b0, 8'h22, 1'b0, 1'b1, 1'b0};
        tbl[4] = '{8'h5A, 1'b1, 1'b1, 8'h5A, 1'b1, 1'b1, 1'b0};
        tbl[5] = '{8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b0};
        tbl[6] = '{8'h00, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1};

        rst_n         = 1'b0;
        bus.rxd       = 1'b1;
        bus.enable_rx = 1'b1;
        bus.rx_ack    = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check_all("reset");
        chk("reset.receiving", bus.receiving, 1'b0);
        rst_n = 1'b1;
        idle(10);

        // Short low glitch on the line is rejected at the start-bit midpoint.
        bus.rxd = 1'b0;
        repeat (4 * DIV) @(negedge clk);
        chk("glitch.receiving_hi", bus.receiving, 1'b1);
        idle(BITCLK);
        chk("glitch.receiving_lo", bus.receiving, 1'b0);
        check_all("glitch");

        for (int i = 0; i < 7; i++) begin
            send_frame(tbl[i].data, tbl[i].stop, ^tbl[i].data);
            chk($sformatf("tbl%0d.d_out", i),         bus.d_out,         tbl[i].e_dout);
            chk($sformatf("tbl%0d.data_valid", i),    bus.data_valid,    tbl[i].e_valid);
            chk($sformatf("tbl%0d.framing_error", i), bus.framing_error, tbl[i].e_fe);
            chk($sformatf("tbl%0d.overrun", i),       bus.overrun,       tbl[i].e_ov);
            chk($sformatf("tbl%0d.parity_error", i),  bus.parity_error,  1'b0);
            if (tbl[i].ack) begin
                do_ack();
                chk($sformatf("tbl%0d.ack_valid", i),   bus.data_valid, 1'b0);
                chk($sformatf("tbl%0d.ack_overrun", i), bus.overrun,    1'b0);
            end
        end
        do_ack();

        // Break: stop bit low, line held low for 40 ticks.
        send_bits(8'hA5, 1'b0, ^(8'hA5));
        model_frame(8'hA5, 1'b0, ^(8'hA5));
        repeat (40 * DIV) @(negedge clk);
        chk("break.receiving", bus.receiving, 1'b1);
        check_all("break");
        idle(8);
        chk("break.released", bus.receiving, 1'b0);
        do_ack();

`ifdef UART_RX_PARITY_EN
        send_frame(8'h07, 1'b1, 1'b0);
        check_all("par_bad");
        chk("par_bad.pe", bus.parity_error, 1'b1);
        do_ack();
        send_frame(8'h07, 1'b1, 1'b1);
        check_all("par_ok");
        do_ack();
`endif

        // Reset during bit 4 with a byte still pending.
        send_frame(8'h3C, 1'b1, ^(8'h3C));
        check_all("pre_rst");
        d = 8'hC3;
        line_bit(1'b0);
        for (int i = 0; i < 4; i++) line_bit(d[i]);
        bus.rxd = d[4];
        repeat (BITCLK / 2) @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        bus.rxd = 1'b1;
        model_reset();
        check_all("mid_rst");
        chk("mid_rst.receiving", bus.receiving, 1'b0);
        rst_n = 1'b1;
        idle(BITCLK * 2);
        chk("post_rst.receiving", bus.receiving, 1'b0);
        send_frame(8'h5A, 1'b1, ^(8'h5A));
        check_all("post_rst");
        do_ack();

        // Disabling mid-frame abandons it silently.
        d = 8'h81;
        line_bit(1'b0);
        line_bit(d[0]);
        line_bit(d[1]);
        bus.enable_rx = 1'b0;
        repeat (2) @(negedge clk);
        chk("abort.receiving", bus.receiving, 1'b0);
        idle(BITCLK * 10);
        bus.enable_rx = 1'b1;
        idle(10);
        check_all("abort");
        send_frame(8'h96, 1'b1, ^(8'h96));
        check_all("after_abort");

        for (int n = 0; n < 24; n++) begin
            d = 8'($urandom);
            s = ($urandom_range(0, 5) != 0);
            p = (^d) ^ ($urandom_range(0, 7) == 0);
            send_frame(d, s, p);
            check_all($sformatf("rnd%0d", n));
            if ($urandom_range(0, 1) == 1) begin
                do_ack();
                check_all($sformatf("rnd%0d_ack", n));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter OVERSAMPLE, default 16, baud_uart ticks per bit period (even, 8..64).
REQ-002 SHALL have port clk, input, 1, general clock; all logic on posedge clk.
REQ-003 SHALL have port rst_n, input, 1; reset is synchronous and active-low.
REQ-004 SHALL have port baud_uart, input, 1, one-clk oversample tick from the baudrate prescaler at OVERSAMPLE x baud.
REQ-005 SHALL have port enable_rx, input, 1, module enable.
REQ-006 SHALL have port rxd, input, 1, asynchronous serial line, idle high.
REQ-007 SHALL have port rx_ack, input, 1, consumer acknowledge of d_out.
REQ-008 SHALL have port d_out, output, 8, last received byte.
REQ-009 SHALL have port data_valid, output, 1, d_out holds an unacknowledged byte.
REQ-010 SHALL have port receiving, output, 1, frame in progress (LED indicator).
REQ-011 SHALL have ports framing_error, parity_error and overrun, output, 1 each, sticky error flags.

Function
REQ-012 SHALL pass rxd through a 2-flop synchronizer; all decisions use the synchronized value (2 clk latency).
REQ-013 SHALL implement states IDLE, START, DATA, PARITY, STOP, WAIT_IDLE; the oversample counter advances only on baud_uart ticks.
REQ-014 IDLE -> START on synchronized rxd = 0; counter cleared.
REQ-015 START: at tick OVERSAMPLE/2-1 (mid start bit) rxd = 0 -> DATA with counter cleared; rxd = 1 -> IDLE (glitch rejected, no flags).
REQ-016 DATA: sample at every OVERSAMPLE-th tick; 8 bits, LSB first, shifted into an internal register; after bit 7 -> PARITY (macro defined) or STOP.
REQ-017 STOP: sample mid stop bit; 1 -> load d_out, set data_valid, return to IDLE; 0 -> set framing_error, leave d_out and data_valid unchanged, go to WAIT_IDLE.
REQ-018 WAIT_IDLE -> IDLE once synchronized rxd = 1 (break handling; no new frame starts during a break).
REQ-019 receiving SHALL be 1 in START, DATA, PARITY, STOP, WAIT_IDLE, and 0 in IDLE.
REQ-020 data_valid SHALL clear the clk after rx_ack = 1; rx_ack while data_valid = 0 has no effect.
REQ-021 A byte completing while data_valid = 1 and rx_ack = 0 SHALL overwrite d_out and set overrun.
REQ-022 A byte completing in the same clk as rx_ack SHALL load d_out and keep data_valid = 1 without setting overrun.
REQ-023 framing_error, parity_error and overrun SHALL clear only on rx_ack = 1 or reset; a set condition in the same clk as rx_ack takes priority.
REQ-024 enable_rx = 0 SHALL force state IDLE, clear the counter and receiving, and hold d_out, data_valid and the error flags.
REQ-025 A frame aborted by enable_rx = 0 SHALL produce no data_valid and no error.

Reset
REQ-026 rst_n = 0 at a clk edge SHALL set state IDLE, d_out = 8'h00, data_valid = 0, receiving = 0, all error flags 0, counter and shift register 0, and synchronizer flops 1.
REQ-027 Reset mid-frame SHALL discard the partial frame; reception resumes at the next falling edge after release.

Configuration
REQ-028 Macro UART_RX_PARITY_EN: when defined, frame = start, 8 data, even parity, stop, and PARITY samples mid-bit.
REQ-029 With UART_RX_PARITY_EN, a parity mismatch (XOR of data and parity bits = 1) SHALL set parity_error; the byte is still loaded when the stop bit = 1.
REQ-030 Without UART_RX_PARITY_EN, frame = start, 8 data, stop; parity_error is tied 0 and the PARITY state is absent.

Verification
REQ-031 OVERSAMPLE = 16, rx frame 0x30 at 16 ticks per bit -> d_out = 0x30, data_valid = 1, all errors 0.
REQ-032 rxd low pulse of 4 ticks -> back to IDLE, receiving drops, data_valid stays 0.
REQ-033 Frame 0xA5 with stop bit 0, then line held low 40 ticks -> framing_error = 1, data_valid = 0, no new frame until rxd returns high.
REQ-034 Frames 0x11 then 0x22 with no rx_ack -> d_out = 0x22, overrun = 1; rx_ack -> data_valid = 0, overrun = 0.
REQ-035 UART_RX_PARITY_EN defined, frame 0x07 with parity bit 0 -> d_out = 0x07, parity_error = 1; same frame with parity bit 1 -> no error.
REQ-036 rst_n = 0 during bit 4 of a frame -> all outputs reset; next 0x5A frame is received correctly.
